// File: rtl/discus_pkg.sv
// Shared definitions for the discus sequencer: condition codes, halt opcode,
// fault codes and the debug-controller state type.
package discus_pkg;

  localparam logic [2:0] COND_NEVER   = 3'b000;
  localparam logic [2:0] COND_ALWAYS  = 3'b001;
  localparam logic [2:0] COND_NEVER2  = 3'b010;
  localparam logic [2:0] COND_ALWAYS2 = 3'b011;
  localparam logic [2:0] COND_Z       = 3'b100;
  localparam logic [2:0] COND_NZ      = 3'b101;
  localparam logic [2:0] COND_C       = 3'b110;
  localparam logic [2:0] COND_NC      = 3'b111;

  localparam logic [7:0] HALT_OPCODE = 8'hAB;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_OVF  = 2'b01;
  localparam logic [1:0] FAULT_UNF  = 2'b10;

  typedef enum logic [1:0] {HALT, RUN, STEP, FAULT} seq_state_e;

  function automatic logic cond_met(input logic [2:0] cond, input logic z, input logic c);
    case (cond)
      COND_ALWAYS, COND_ALWAYS2: return 1'b1;
      COND_Z:                    return z;
      COND_NZ:                   return !z;
      COND_C:                    return c;
      COND_NC:                   return !c;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/discus_rstack.sv
// Return-address LIFO. Push on full and pop on empty are dropped; the
// sequencer never issues push and pop together.
module discus_rstack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [SP_W-1:0]  depth_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             do_push, do_pop;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign depth_o = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + SP_W'(1);
    else if (do_pop) sp_d = sp_q - SP_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sp_q <= '0;
    else          sp_q <= sp_d;
  end

  // Index by comparison so a non-power-of-two depth never forms an out-of-range address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && sp_q == SP_W'(i)) mem_q[i] <= data_i;
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) top_o = mem_q[i];
    end
  end

endmodule

// File: rtl/discus_seq.sv
// Instruction sequencer: PC, prefix/jump decode, branch conditions,
// return stack and run/halt/single-step debug control.
//   state | meaning
//   HALT  | idle, waiting for run or a step request
//   RUN   | one instruction retires per cycle while run is held
//   STEP  | retire exactly one instruction, then back to HALT
//   FAULT | stack overflow/underflow seen, waits for clear_fault
module discus_seq
  import discus_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      instr,
  input  logic            zflag,
  input  logic            cflag,
  input  logic            run,
  input  logic            step_req,
  input  logic            clear_fault,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic [7:0]      instr_q,
  output logic            step_ack,
  output logic            halted,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [SP_W-1:0] depth
);

  localparam int PREFIX_N = (PC_W + 3) / 6;
  localparam int PCNT_W   = $clog2(PREFIX_N + 1);
  // Only the low PC_W-2 prefix bits can ever reach the target, so keep just those.
  localparam int PFX_W    = PC_W - 2;

  seq_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [PFX_W-1:0]  prefix_q, prefix_d, pfx_shift;
  logic [7:0]        ins_q, ins_d;
  logic              step_ack_q, step_ack_d;
  logic [1:0]        fault_code_q, fault_code_d;

  logic [PC_W-1:0]   stk_top;
  logic              stk_full, stk_empty;
  logic              is_pfx, is_jump, is_ret, is_halt, taken;
  logic              call_taken, jump_taken, ret_taken;
  logic              ovf, unf, fault_hit, exec_en;
  logic [PC_W-1:0]   target;

  generate
    if (PFX_W == 6) begin : g_pfx_one
      assign pfx_shift = instr[5:0];
    end else begin : g_pfx_chain
      assign pfx_shift = {prefix_q[PFX_W-7:0], instr[5:0]};
    end
  endgenerate

  assign is_pfx     = (instr[7:6] == 2'b00);
  assign is_jump    = is_pfx && (pcnt_q == PCNT_W'(PREFIX_N));
  assign is_ret     = (instr[7:5] == 3'b101);
  assign is_halt    = (instr == HALT_OPCODE);
  assign taken      = cond_met(instr[4:2], zflag, cflag);
  assign jump_taken = is_jump && taken;
  assign call_taken = jump_taken && instr[5];
  assign ret_taken  = is_ret && taken;
  assign target     = {prefix_q, instr[1:0]};

  assign ovf       = call_taken && stk_full;
  assign unf       = ret_taken && stk_empty;
  assign fault_hit = ovf || unf;
  assign exec_en   = (state_q == RUN && run) || (state_q == STEP);
  assign retire    = exec_en && !fault_hit;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pcnt_d       = pcnt_q;
    prefix_d     = prefix_q;
    ins_d        = ins_q;
    step_ack_d   = 1'b0;
    fault_code_d = fault_code_q;

    case (state_q)
      HALT: begin
        if (run)           state_d = RUN;
        else if (step_req) state_d = STEP;
      end
      RUN: begin
        if (!run)           state_d = HALT;
        else if (fault_hit) state_d = FAULT;
        else if (is_halt)   state_d = HALT;
      end
      STEP:    state_d = fault_hit ? FAULT : HALT;
      FAULT: begin
        if (clear_fault) begin
          state_d      = HALT;
          fault_code_d = FAULT_NONE;
        end
      end
      default: state_d = HALT;
    endcase

    if (exec_en && fault_hit) fault_code_d = ovf ? FAULT_OVF : FAULT_UNF;

    if (retire) begin
      ins_d      = instr;
      step_ack_d = (state_q == STEP);
      if (ret_taken)       pc_d = stk_top + PC_W'(1);
      else if (jump_taken) pc_d = target;
      else                 pc_d = pc_q + PC_W'(1);
      if (!is_pfx || is_jump) begin
        pcnt_d = '0;
      end else begin
        pcnt_d   = pcnt_q + PCNT_W'(1);
        prefix_d = pfx_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HALT;
      pc_q         <= '0;
      pcnt_q       <= '0;
      prefix_q     <= '0;
      ins_q        <= '0;
      step_ack_q   <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pcnt_q       <= pcnt_d;
      prefix_q     <= prefix_d;
      ins_q        <= ins_d;
      step_ack_q   <= step_ack_d;
      fault_code_q <= fault_code_d;
    end
  end

  discus_rstack #(
    .WIDTH (PC_W),
    .DEPTH (STACK_DEPTH),
    .SP_W  (SP_W)
  ) u_rstack (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (retire && call_taken),
    .pop_i   (retire && ret_taken),
    .data_i  (pc_q),
    .top_o   (stk_top),
    .depth_o (depth),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign pc         = pc_q;
  assign instr_q    = ins_q;
  assign step_ack   = step_ack_q;
  assign fault_code = fault_code_q;
  assign halted     = (state_q == HALT) || (state_q == FAULT);
  assign fault      = (state_q == FAULT);

endmodule
